// File: rtl/life_pkg.sv
// Shared types and rule constants for the Game-of-Life generation controller.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  typedef logic [3:0] count_t;

  localparam count_t LIFE_BIRTH   = 4'd3;
  localparam count_t LIFE_SURVIVE = 4'd2;

  function automatic logic life_rule(input logic alive, input count_t n);
    return (n == LIFE_BIRTH) | (alive & (n == LIFE_SURVIVE));
  endfunction

endpackage

// File: rtl/life_gen_controller_if.sv
// Control/load handshake and board readout between the user logic (master)
// and the generation controller (slave).
interface life_gen_controller_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int CW   = 16
);
  logic                    step;
  logic                    load;
  logic [$clog2(ROWS)-1:0] load_row;
  logic [COLS-1:0]         load_data;
  logic                    busy;
  logic                    gen_done;
  logic [ROWS*COLS-1:0]    board;
  logic [CW-1:0]           gen_count;

  modport master (
    output step, load, load_row, load_data,
    input  busy, gen_done, board, gen_count
  );

  modport slave (
    input  step, load, load_row, load_data,
    output busy, gen_done, board, gen_count
  );
endinterface

// File: rtl/life_neighbor_count.sv
// Combinational population count of the eight neighbour bits of one cell.
module life_neighbor_count
  import life_pkg::*;
(
  input  logic [7:0] nbr_i,
  output count_t     count_o
);

  // Sum the eight neighbour bits.
  always_comb begin
    count_o = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count_o = count_o + {3'b000, nbr_i[i]};
    end
  end

endmodule

// File: rtl/life_gen_controller.sv
// Sweeps one Game-of-Life generation into a shadow board and commits it atomically.
// Define LIFE_TORUS_EN to wrap board edges; otherwise off-board neighbours are dead.
module life_gen_controller
  import life_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int CW   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  life_gen_controller_if.slave  bus
);

  localparam int NCELL = ROWS * COLS;
  localparam int RW    = $clog2(ROWS);
  localparam int COLW  = $clog2(COLS);
  localparam int IDXW  = $clog2(NCELL);

  state_t            state_q, state_d;
  logic [NCELL-1:0]  board_q, board_d;
  logic [NCELL-1:0]  shadow_q, shadow_d;
  logic [RW-1:0]     r_q, r_d;
  logic [COLW-1:0]   c_q, c_d;
  logic              busy_q, busy_d;
  logic              gen_done_q, gen_done_d;
  logic [CW-1:0]     gen_count_q, gen_count_d;

  logic [7:0]        nbr_s;
  count_t            count_s;
  logic [IDXW-1:0]   cell_idx_s;
  logic              alive_s;

  function automatic logic cell_at(input logic [NCELL-1:0] b, input int rr, input int cc);
    int   wr;
    int   wc;
    logic v;
`ifdef LIFE_TORUS_EN
    wr = (rr + ROWS) % ROWS;
    wc = (cc + COLS) % COLS;
    v  = b[IDXW'(wr * COLS + wc)];
`else
    wr = rr;
    wc = cc;
    if ((wr < 0) || (wr >= ROWS) || (wc < 0) || (wc >= COLS)) begin
      v = 1'b0;
    end else begin
      v = b[IDXW'(wr * COLS + wc)];
    end
`endif
    return v;
  endfunction

  // Gather the eight neighbours of the cell under the sweep pointer.
  always_comb begin
    nbr_s[0]   = cell_at(board_q, int'(r_q) - 1, int'(c_q) - 1);
    nbr_s[1]   = cell_at(board_q, int'(r_q) - 1, int'(c_q));
    nbr_s[2]   = cell_at(board_q, int'(r_q) - 1, int'(c_q) + 1);
    nbr_s[3]   = cell_at(board_q, int'(r_q),     int'(c_q) - 1);
    nbr_s[4]   = cell_at(board_q, int'(r_q),     int'(c_q) + 1);
    nbr_s[5]   = cell_at(board_q, int'(r_q) + 1, int'(c_q) - 1);
    nbr_s[6]   = cell_at(board_q, int'(r_q) + 1, int'(c_q));
    nbr_s[7]   = cell_at(board_q, int'(r_q) + 1, int'(c_q) + 1);
    cell_idx_s = IDXW'(int'(r_q) * COLS + int'(c_q));
    alive_s    = board_q[cell_idx_s];
  end

  life_neighbor_count u_count (
    .nbr_i   (nbr_s),
    .count_o (count_s)
  );

  // Next-state and datapath updates for the IDLE/SCAN/COMMIT sequence.
  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    shadow_d    = shadow_q;
    r_d         = r_q;
    c_d         = c_q;
    busy_d      = busy_q;
    gen_done_d  = 1'b0;
    gen_count_d = gen_count_q;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          // Rows outside the board never match, so such loads fall through harmlessly.
          for (int rr = 0; rr < ROWS; rr++) begin
            if (bus.load_row == RW'(rr)) begin
              board_d[rr*COLS +: COLS] = bus.load_data;
            end else begin
              board_d[rr*COLS +: COLS] = board_q[rr*COLS +: COLS];
            end
          end
        end else if (bus.step) begin
          busy_d  = 1'b1;
          r_d     = '0;
          c_d     = '0;
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        shadow_d[cell_idx_s] = life_rule(alive_s, count_s);
        if (c_q == COLW'(COLS - 1)) begin
          c_d = '0;
          if (r_q == RW'(ROWS - 1)) begin
            r_d     = '0;
            state_d = COMMIT;
          end else begin
            r_d = r_q + RW'(1);
          end
        end else begin
          c_d = c_q + COLW'(1);
        end
      end
      COMMIT: begin
        board_d     = shadow_q;
        gen_count_d = gen_count_q + CW'(1);
        gen_done_d  = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      board_q     <= '0;
      shadow_q    <= '0;
      r_q         <= '0;
      c_q         <= '0;
      busy_q      <= 1'b0;
      gen_done_q  <= 1'b0;
      gen_count_q <= '0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      shadow_q    <= shadow_d;
      r_q         <= r_d;
      c_q         <= c_d;
      busy_q      <= busy_d;
      gen_done_q  <= gen_done_d;
      gen_count_q <= gen_count_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.gen_done  = gen_done_q;
  assign bus.board     = board_q;
  assign bus.gen_count = gen_count_q;

endmodule

// File: tb/tb_life_gen_controller.sv
// Directed, table-driven bench for life_gen_controller (8x8, 16-bit counter).
module tb_life_gen_controller;
  import life_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   exp_gc;

  life_gen_controller_if #(.ROWS(8), .COLS(8), .CW(16)) bus ();

  life_gen_controller #(.ROWS(8), .COLS(8), .CW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] init;
    logic [63:0] exp_b;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [63:0] cb(input int r, input int c);
    logic [63:0] v;
    v = '0;
    v[r*8+c] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_gc = 0;
  endtask

  task automatic load_board(input logic [63:0] b);
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      bus.load      = 1'b1;
      bus.load_row  = 3'(r);
      bus.load_data = b[r*8 +: 8];
    end
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  // Ends at the negedge where gen_done is seen (the commit cycle).
  task automatic do_step(output int busy_cycles, output bit ok);
    @(negedge clk);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    busy_cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.gen_done) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy) busy_cycles++;
      @(negedge clk);
    end
    check("gen_done_seen", 64'(ok), 64'd1);
    check("busy_low_at_done", 64'(bus.busy), 64'd0);
    if (ok) exp_gc++;
  endtask

  logic [63:0] blinker_h;
  logic [63:0] blinker_v;
  logic [63:0] block_b;
  int          bc;
  bit          ok;
  bit          seen;

  initial begin
    checks   = 0;
    failures = 0;
    exp_gc   = 0;
    reset         = 1'b1;
    bus.step      = 1'b0;
    bus.load      = 1'b0;
    bus.load_row  = 3'd0;
    bus.load_data = 8'd0;

    blinker_h = cb(3,2) | cb(3,3) | cb(3,4);
    blinker_v = cb(2,3) | cb(3,3) | cb(4,3);
    block_b   = cb(1,1) | cb(1,2) | cb(2,1) | cb(2,2);

    vecs[0].init = 64'd0;                      vecs[0].exp_b = 64'd0;
    vecs[1].init = blinker_h;                  vecs[1].exp_b = blinker_v;
    vecs[2].init = blinker_v;                  vecs[2].exp_b = blinker_h;
    vecs[3].init = block_b;                    vecs[3].exp_b = block_b;
    vecs[4].init = cb(7,7);                    vecs[4].exp_b = 64'd0;
    vecs[5].init = cb(0,0) | cb(0,1) | cb(1,0);
    vecs[5].exp_b = cb(0,0) | cb(0,1) | cb(1,0) | cb(1,1);
    vecs[6].init = cb(0,3) | cb(0,4) | cb(0,5);
`ifdef LIFE_TORUS_EN
    vecs[6].exp_b = cb(7,4) | cb(0,4) | cb(1,4);
`else
    vecs[6].exp_b = cb(0,4) | cb(1,4);
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_board", bus.board, 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_gen_done", 64'(bus.gen_done), 64'd0);
    check("reset_gen_count", 64'(bus.gen_count), 64'd0);

    // Empty board: latency, busy width, one-cycle pulse.
    do_step(bc, ok);
    check("empty_busy_cycles", 64'(bc), 64'd65);
    check("empty_board", bus.board, 64'd0);
    check("empty_gen_count", 64'(bus.gen_count), 64'd1);
    @(negedge clk);
    check("gen_done_one_cycle", 64'(bus.gen_done), 64'd0);

    // Table-driven single generations.
    for (int i = 0; i < 7; i++) begin
      load_board(vecs[i].init);
      check($sformatf("vec%0d_loaded", i), bus.board, vecs[i].init);
      do_step(bc, ok);
      check($sformatf("vec%0d_board", i), bus.board, vecs[i].exp_b);
      check($sformatf("vec%0d_gen_count", i), 64'(bus.gen_count), 64'(exp_gc));
    end

    // Blinker oscillates back after two generations.
    do_reset();
    load_board(blinker_h);
    do_step(bc, ok);
    check("blinker_gen1", bus.board, blinker_v);
    do_step(bc, ok);
    check("blinker_gen2", bus.board, blinker_h);
    check("blinker_gen_count", 64'(bus.gen_count), 64'd2);

    // Still life over three generations; third step issued back-to-back in the gen_done cycle.
    load_board(block_b);
    do_step(bc, ok);
    check("block_gen1", bus.board, block_b);
    do_step(bc, ok);
    check("block_gen2", bus.board, block_b);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    check("back_to_back_accept", 64'(bus.busy), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.gen_done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (seen) exp_gc++;
    check("b2b_done_seen", 64'(seen), 64'd1);
    check("block_gen3", bus.board, block_b);
    check("block_gen_count", 64'(bus.gen_count), 64'(exp_gc));

    // Protocol: steps and a load during busy are ignored.
    load_board(64'd0);
    @(negedge clk);
    bus.step = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.step = 1'b0;
      @(negedge clk);
      bus.step = 1'b1;
      @(negedge clk);
    end
    bus.step      = 1'b0;
    bus.load      = 1'b1;
    bus.load_row  = 3'd0;
    bus.load_data = 8'hFF;
    @(negedge clk);
    bus.load = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.gen_done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (seen) exp_gc++;
    check("busy_protocol_done", 64'(seen), 64'd1);
    check("busy_load_ignored", bus.board, 64'd0);
    repeat (80) @(negedge clk);
    check("steps_not_queued", 64'(bus.gen_count), 64'(exp_gc));
    check("idle_after_protocol", 64'(bus.busy), 64'd0);

    // Load and step in the same IDLE cycle: load wins.
    bus.load      = 1'b1;
    bus.step      = 1'b1;
    bus.load_row  = 3'd2;
    bus.load_data = 8'h5A;
    @(negedge clk);
    bus.load = 1'b0;
    bus.step = 1'b0;
    check("load_step_row", 64'(bus.board[23:16]), 64'h5A);
    check("load_step_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("load_step_busy_later", 64'(bus.busy), 64'd0);

    // Reset in the middle of a scan.
    load_board(blinker_h);
    @(negedge clk);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    repeat (29) @(negedge clk);
    check("midscan_busy_before", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_gc = 0;
    check("midscan_board", bus.board, 64'd0);
    check("midscan_gen_count", 64'(bus.gen_count), 64'd0);
    check("midscan_busy", 64'(bus.busy), 64'd0);
    check("midscan_gen_done", 64'(bus.gen_done), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (bus.gen_done || bus.busy) seen = 1'b1;
      @(negedge clk);
    end
    check("midscan_no_late_done", 64'(seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
